// File: rtl/cascade_counter_pkg.sv
// Shared constants and types for the cascaded modulo counter.
// Stage step decisions are named so the datapath mux reads as intent.
package cascade_counter_pkg;

  localparam int DEFAULT_NUM_STAGES = 3;
  localparam int DEFAULT_WIDTH      = 6;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  typedef enum logic [2:0] {
    STEP_HOLD,
    STEP_LOAD,
    STEP_INC,
    STEP_DEC,
    STEP_WRAP_LOW,
    STEP_WRAP_HIGH,
    STEP_CLAMP
  } step_kind_e;

endpackage

// File: rtl/cascade_counter_stage.sv
// One counter stage: counts over 0..limit_i inclusive, clamps out-of-range
// values, and reports whether it is terminal and whether this step wraps.
module counter_stage
  import cascade_counter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stepEn_i,
  input  logic             up_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] loadVal_i,
  input  logic [WIDTH-1:0] limit_i,
  output logic [WIDTH-1:0] count_o,
  output logic             wrap_o,
  output logic             terminal_o,
  output logic             wrapNow_o
);

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q;
  step_kind_e       kind;

  function automatic logic [WIDTH-1:0] clampToLimit(input logic [WIDTH-1:0] value,
                                                    input logic [WIDTH-1:0] lim);
    return (value > lim) ? lim : value;
  endfunction

  // A zero limit pins the stage at 0, so it is always terminal.
  assign terminal_o = (limit_i == '0) ||
                      ((up_i == DIR_UP) ? (count_q == limit_i) : (count_q == '0));

  always_comb begin
    kind = STEP_HOLD;
    if (load_i) begin
      kind = STEP_LOAD;
    end else if (stepEn_i) begin
      if (limit_i == '0) begin
        kind = STEP_WRAP_LOW;
      end else if (up_i == DIR_UP) begin
        kind = (count_q >= limit_i) ? STEP_WRAP_LOW : STEP_INC;
      end else if (count_q == '0) begin
        kind = STEP_WRAP_HIGH;
      end else if (count_q > limit_i) begin
        kind = STEP_CLAMP;
      end else begin
        kind = STEP_DEC;
      end
    end
  end

  always_comb begin
    count_d = count_q;
    case (kind)
      STEP_LOAD:      count_d = clampToLimit(loadVal_i, limit_i);
      STEP_INC:       count_d = count_q + WIDTH'(1);
      STEP_DEC:       count_d = count_q - WIDTH'(1);
      STEP_WRAP_LOW:  count_d = '0;
      STEP_WRAP_HIGH: count_d = limit_i;
      STEP_CLAMP:     count_d = limit_i;
      default:        count_d = count_q;
    endcase
  end

  assign wrapNow_o = (kind == STEP_WRAP_LOW) || (kind == STEP_WRAP_HIGH);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrapNow_o;
    end
  end

  assign count_o = count_q;
  assign wrap_o  = wrap_q;

endmodule

// File: rtl/cascade_counter.sv
// Chain of modulo counter stages; a higher stage steps only when every
// lower stage is terminal in the same cycle. Rollover flags a full wrap.
module cascade_counter
  import cascade_counter_pkg::*;
#(
  parameter int NUM_STAGES = DEFAULT_NUM_STAGES,
  parameter int WIDTH      = DEFAULT_WIDTH
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        en,
  input  logic                        up,
  input  logic                        load,
  input  logic [NUM_STAGES*WIDTH-1:0] loadVal,
  input  logic [NUM_STAGES*WIDTH-1:0] limit,
  output logic [NUM_STAGES*WIDTH-1:0] count,
  output logic [NUM_STAGES-1:0]       wrap,
  output logic                        rollover
);

  logic [NUM_STAGES-1:0] stepEn;
  logic [NUM_STAGES-1:0] terminal;
  logic [NUM_STAGES-1:0] wrapNow;
  logic                  rollover_q, rollover_d;

  always_comb begin
    stepEn[0] = en;
    for (int i = 1; i < NUM_STAGES; i++) begin
      stepEn[i] = stepEn[i-1] && terminal[i-1];
    end
  end

  for (genvar g = 0; g < NUM_STAGES; g++) begin : gStage
    counter_stage #(
      .WIDTH (WIDTH)
    ) uStage (
      .clk        (clk),
      .reset      (reset),
      .stepEn_i   (stepEn[g]),
      .up_i       (up),
      .load_i     (load),
      .loadVal_i  (loadVal[g*WIDTH +: WIDTH]),
      .limit_i    (limit[g*WIDTH +: WIDTH]),
      .count_o    (count[g*WIDTH +: WIDTH]),
      .wrap_o     (wrap[g]),
      .terminal_o (terminal[g]),
      .wrapNow_o  (wrapNow[g])
    );
  end

  // Load suppresses stepping in every stage, so it can never be a rollover.
  assign rollover_d = !load && (&wrapNow);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rollover_q <= 1'b0;
    end else begin
      rollover_q <= rollover_d;
    end
  end

  assign rollover = rollover_q;

endmodule

// File: tb/tb_cascade_counter.sv
// Self-checking bench for cascade_counter: directed vector table, corner
// sequences, and randomized traffic against a carry-chain reference model.
module tb_cascade_counter;

  localparam int NS = 3;
  localparam int W  = 6;
  localparam int TW = NS * W;

  logic          clk = 1'b0;
  logic          reset;
  logic          en, up, load;
  logic [TW-1:0] loadVal, limit;
  logic [TW-1:0] count;
  logic [NS-1:0] wrap;
  logic          rollover;

  int checks = 0;
  int errors = 0;

  int mC [NS];
  bit mW [NS];
  bit mR;

  typedef struct {
    logic          en;
    logic          up;
    logic          load;
    logic [TW-1:0] loadVal;
    logic [TW-1:0] limit;
    logic [TW-1:0] expCount;
    logic [NS-1:0] expWrap;
    logic          expRoll;
  } vec_t;

  vec_t tbl [12];

  cascade_counter #(
    .NUM_STAGES (NS),
    .WIDTH      (W)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .up       (up),
    .load     (load),
    .loadVal  (loadVal),
    .limit    (limit),
    .count    (count),
    .wrap     (wrap),
    .rollover (rollover)
  );

  always #5 clk = ~clk;

  function automatic logic [TW-1:0] p3(input int s2, input int s1, input int s0);
    return {W'(s2), W'(s1), W'(s0)};
  endfunction

  function automatic logic [TW-1:0] modelCount();
    return p3(mC[2], mC[1], mC[0]);
  endfunction

  function automatic logic [NS-1:0] modelWrap();
    return {mW[2], mW[1], mW[0]};
  endfunction

  task automatic modelReset();
    for (int i = 0; i < NS; i++) begin
      mC[i] = 0;
      mW[i] = 0;
    end
    mR = 0;
  endtask

  // Ripple-carry view: a step propagates upward while the stages it passes
  // through were at their end value before the edge.
  task automatic modelEdge(input bit e, input bit u, input bit ld,
                           input logic [TW-1:0] lv, input logic [TW-1:0] lim);
    bit carry = e;
    bit all = 1;
    for (int i = 0; i < NS; i++) begin
      int l = int'(lim[i*W +: W]);
      int v = int'(lv[i*W +: W]);
      int c = mC[i];
      bit term = (l == 0) || (u ? (c == l) : (c == 0));
      mW[i] = 0;
      if (ld) begin
        mC[i] = (v < l) ? v : l;
      end else if (carry) begin
        if (l == 0) begin
          mC[i] = 0; mW[i] = 1;
        end else if (u) begin
          if (c >= l) begin mC[i] = 0; mW[i] = 1; end
          else mC[i] = c + 1;
        end else begin
          if (c == 0) begin mC[i] = l; mW[i] = 1; end
          else if (c > l) mC[i] = l;
          else mC[i] = c - 1;
        end
      end
      carry = carry && term;
      all = all && mW[i];
    end
    mR = !ld && all;
  endtask

  task automatic checkOutput(input string name, input logic [TW-1:0] expC,
                             input logic [NS-1:0] expW, input logic expR);
    checks++;
    if (count !== expC) begin
      errors++;
      $display("[TB] FAIL %s count got %h expected %h", name, count, expC);
    end
    checks++;
    if (wrap !== expW) begin
      errors++;
      $display("[TB] FAIL %s wrap got %b expected %b", name, wrap, expW);
    end
    checks++;
    if (rollover !== expR) begin
      errors++;
      $display("[TB] FAIL %s rollover got %b expected %b", name, rollover, expR);
    end
  endtask

  task automatic applyStimulus(input bit e, input bit u, input bit ld,
                               input logic [TW-1:0] lv, input logic [TW-1:0] lim);
    en = e; up = u; load = ld; loadVal = lv; limit = lim;
  endtask

  task automatic tick(input bit chk, input string name);
    @(posedge clk);
    #1;
    modelEdge(en, up, load, loadVal, limit);
    if (chk) checkOutput(name, modelCount(), modelWrap(), mR);
  endtask

  // Reset is pulsed between edges so its effect must be visible without a clock.
  task automatic doReset(input string name);
    reset = 1'b1;
    #2;
    checkOutput(name, '0, '0, 1'b0);
    reset = 1'b0;
    #1;
    modelReset();
  endtask

  function automatic vec_t mk(input bit e, input bit u, input bit ld,
                              input logic [TW-1:0] lv, input logic [TW-1:0] lim,
                              input logic [TW-1:0] ec, input logic [NS-1:0] ew,
                              input logic er);
    vec_t v;
    v.en = e; v.up = u; v.load = ld; v.loadVal = lv; v.limit = lim;
    v.expCount = ec; v.expWrap = ew; v.expRoll = er;
    return v;
  endfunction

  initial begin
    logic [TW-1:0] defLim;
    logic [TW-1:0] lim40;
    defLim = p3(23, 59, 59);
    lim40  = p3(23, 59, 40);

    tbl[0]  = mk(0, 1, 1, p3(23, 59, 59), defLim, p3(23, 59, 59), 3'b000, 0);
    tbl[1]  = mk(1, 1, 0, '0,             defLim, p3(0, 0, 0),    3'b111, 1);
    tbl[2]  = mk(0, 1, 0, '0,             defLim, p3(0, 0, 0),    3'b000, 0);
    tbl[3]  = mk(1, 0, 0, '0,             defLim, p3(23, 59, 59), 3'b111, 1);
    tbl[4]  = mk(1, 0, 0, '0,             defLim, p3(23, 59, 58), 3'b000, 0);
    tbl[5]  = mk(1, 1, 0, '0,             defLim, p3(23, 59, 59), 3'b000, 0);
    tbl[6]  = mk(0, 1, 1, p3(5, 30, 17),  defLim, p3(5, 30, 17),  3'b000, 0);
    tbl[7]  = mk(1, 1, 0, '0,             defLim, p3(5, 30, 18),  3'b000, 0);
    tbl[8]  = mk(1, 1, 1, p3(63, 63, 63), defLim, p3(23, 59, 59), 3'b000, 0);
    tbl[9]  = mk(1, 1, 0, '0,             defLim, p3(0, 0, 0),    3'b111, 1);
    tbl[10] = mk(1, 0, 0, '0,             lim40,  p3(23, 59, 40), 3'b111, 1);
    tbl[11] = mk(1, 1, 0, '0,             defLim, p3(23, 59, 41), 3'b000, 0);

    applyStimulus(0, 1, 0, '0, defLim);
    modelReset();
    reset = 1'b1;
    #2;
    checkOutput("reset_state", '0, '0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("idle_after_reset", '0, '0, 1'b0);

    for (int i = 0; i < 12; i++) begin
      applyStimulus(tbl[i].en, tbl[i].up, tbl[i].load, tbl[i].loadVal, tbl[i].limit);
      tick(0, "");
      checkOutput($sformatf("vec%0d", i), tbl[i].expCount, tbl[i].expWrap, tbl[i].expRoll);
    end

    // Stage 0 runs its full range, then carries into stage 1.
    doReset("s1_reset");
    applyStimulus(1, 1, 0, '0, defLim);
    for (int i = 0; i < 59; i++) tick(1, "s1_run");
    checkOutput("s1_at_59", p3(0, 0, 59), 3'b000, 0);
    tick(0, "");
    checkOutput("s1_wrap", p3(0, 1, 0), 3'b001, 0);
    applyStimulus(0, 1, 0, '0, defLim);
    tick(0, "");
    checkOutput("s1_wrap_clear", p3(0, 1, 0), 3'b000, 0);

    // Out-of-range values: 63 is the largest loadable stage value here.
    applyStimulus(0, 1, 1, p3(0, 0, 63), defLim);
    tick(0, "");
    checkOutput("s4_load_clamp", p3(0, 0, 59), 3'b000, 0);
    applyStimulus(1, 1, 0, '0, lim40);
    tick(0, "");
    checkOutput("s4_up_over", p3(0, 0, 0), 3'b001, 0);
    applyStimulus(0, 1, 1, p3(0, 0, 63), defLim);
    tick(0, "");
    checkOutput("s4_reload", p3(0, 0, 59), 3'b000, 0);
    applyStimulus(1, 0, 0, '0, lim40);
    tick(0, "");
    checkOutput("s4_down_clamp", p3(0, 0, 40), 3'b000, 0);

    // Asynchronous reset mid-count, then recovery.
    applyStimulus(0, 1, 1, p3(5, 30, 17), defLim);
    tick(0, "");
    checkOutput("s5_loaded", p3(5, 30, 17), 3'b000, 0);
    applyStimulus(1, 1, 0, '0, defLim);
    #2;
    doReset("s5_async_reset");
    tick(0, "");
    checkOutput("s5_recover", p3(0, 0, 1), 3'b000, 0);

    // Zero-limit middle stage is transparent to the carry.
    doReset("s6_reset");
    applyStimulus(1, 1, 0, '0, p3(23, 0, 59));
    for (int i = 0; i < 59; i++) tick(1, "s6_run");
    tick(0, "");
    checkOutput("s6_first_carry", p3(1, 0, 0), 3'b011, 0);
    for (int i = 0; i < 59; i++) tick(1, "s6_run2");
    tick(0, "");
    checkOutput("s6_second_carry", p3(2, 0, 0), 3'b011, 0);

    for (int n = 0; n < 600; n++) begin
      logic [TW-1:0] lv, lim;
      lim = limit;
      if ($urandom_range(0, 14) == 0) begin
        for (int s = 0; s < NS; s++) begin
          lim[s*W +: W] = ($urandom_range(0, 7) == 0) ? W'(0) : W'($urandom_range(1, 63));
        end
      end
      lv = TW'({$urandom, $urandom});
      applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                    $urandom_range(0, 9) == 0, lv, lim);
      if ($urandom_range(0, 149) == 0) doReset("rand_reset");
      tick(1, "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
